rv_burst_fifo: RTL and testbench

RV_BURST_FIFO -- requirements
Module: rv_burst_fifo

---
 rtl/rv_burst_fifo_pkg.sv | 20 ++
 rtl/rv_burst_fifo_ptr_counter.sv | 34 +++
 rtl/rv_burst_fifo.sv | 66 ++++++
 tb/tb_rv_burst_fifo.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rv_burst_fifo_pkg.sv
// Shared defaults and helpers for the ready/valid burst FIFO.
package rv_burst_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 4;

    // Pointer width is address width plus one wrap bit, so that full and
    // empty remain distinguishable when the pointers are equal modulo DEPTH.
    function automatic int ptr_width(input int depth);
        int addr_w;
        addr_w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < depth) begin
                addr_w = i + 1;
            end
        end
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/rv_burst_fifo_ptr_counter.sv
// Wrapping pointer counter used for both the write and the read side.
// The counter is PTR_W bits wide, so it naturally wraps modulo 2*DEPTH.
module fifo_ptr_counter #(
    parameter int PTR_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Advance by one on each accepted transfer.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    // Pointer register, cleared immediately by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/rv_burst_fifo.sv
// Ready/valid FIFO between an upstream producer and the downstream Pacer.
// Both handshake outputs depend only on the registered pointers, so there is
// no combinational path across the FIFO in either direction.
module rv_burst_fifo
    import rv_burst_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                    clock_port,
    input  logic                    reset_port,
    input  logic [DATA_WIDTH-1:0]   input_port_data,
    input  logic                    input_port_valid,
    output logic                    input_port_ready,
    output logic [DATA_WIDTH-1:0]   output_port_data,
    output logic                    output_port_valid,
    input  logic                    output_port_ready,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int PTR_W  = ptr_width(DEPTH);
    localparam int ADDR_W = PTR_W - 1;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      level_w;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Occupancy is the pointer difference; the extra bit resolves full vs empty.
    always_comb begin
        level_w           = wr_ptr - rd_ptr;
        input_port_ready  = (level_w != PTR_W'(DEPTH));
        output_port_valid = (level_w != '0);
        push              = input_port_valid  & input_port_ready;
        pop               = output_port_valid & output_port_ready;
    end

    assign level            = level_w;
    assign output_port_data = mem_q[rd_ptr[ADDR_W-1:0]];

    fifo_ptr_counter #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk_i  (clock_port),
        .rst_ni (reset_port),
        .inc_i  (push),
        .ptr_o  (wr_ptr)
    );

    fifo_ptr_counter #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk_i  (clock_port),
        .rst_ni (reset_port),
        .inc_i  (pop),
        .ptr_o  (rd_ptr)
    );

    // Storage entries: each one loads only when a push targets it; no reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge clock_port) begin
            if (push && (wr_ptr[ADDR_W-1:0] == ADDR_W'(gi))) begin
                mem_q[gi] <= input_port_data;
            end
        end
    end

endmodule

// File: tb/tb_rv_burst_fifo.sv
module tb_rv_burst_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clock_port;
    logic          reset_port;
    logic [DW-1:0] input_port_data;
    logic          input_port_valid;
    logic          input_port_ready;
    logic [DW-1:0] output_port_data;
    logic          output_port_valid;
    logic          output_port_ready;
    logic [2:0]    level;

    int total;
    int bad;

    logic [DW-1:0] mq[$];

    rv_burst_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock_port        (clock_port),
        .reset_port        (reset_port),
        .input_port_data   (input_port_data),
        .input_port_valid  (input_port_valid),
        .input_port_ready  (input_port_ready),
        .output_port_data  (output_port_data),
        .output_port_valid (output_port_valid),
        .output_port_ready (output_port_ready),
        .level             (level)
    );

    initial clock_port = 1'b0;
    always #5 clock_port = ~clock_port;

    typedef struct {
        logic          vin;
        logic [DW-1:0] din;
        logic          rdy;
        int            exp_level;
        logic          exp_in_ready;
        logic          exp_out_valid;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock of stimulus; the reference queue follows the handshake rules.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
        bit do_push;
        bit do_pop;
        input_port_valid  = v;
        input_port_data   = d;
        output_port_ready = r;
        do_push = v && (mq.size() != DEPTH);
        do_pop  = r && (mq.size() != 0);
        @(posedge clock_port);
        #1;
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(d);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".level"}, 32'(level), 32'(mq.size()));
        check({tag, ".in_ready"}, 32'(input_port_ready), 32'(mq.size() != DEPTH));
        check({tag, ".out_valid"}, 32'(output_port_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) check({tag, ".data"}, 32'(output_port_data), 32'(mq[0]));
    endtask

    initial begin
        int got;
        int sent;
        int pcnt;
        int budget;
        int max_level;
        logic prdy;
        logic [DW-1:0] rx[$];

        total = 0;
        bad   = 0;
        reset_port        = 1'b0;
        input_port_valid  = 1'b0;
        input_port_data   = '0;
        output_port_ready = 1'b0;

        // Single transfer, fill, full-with-pop, then drain.
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1, 1'b1, 1'b1, 8'hA5};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 8'h01, 1'b0, 1, 1'b1, 1'b1, 8'h01};
        vecs[3]  = '{1'b1, 8'h02, 1'b0, 2, 1'b1, 1'b1, 8'h01};
        vecs[4]  = '{1'b1, 8'h03, 1'b0, 3, 1'b1, 1'b1, 8'h01};
        vecs[5]  = '{1'b1, 8'h04, 1'b0, 4, 1'b0, 1'b1, 8'h01};
        vecs[6]  = '{1'b1, 8'h05, 1'b0, 4, 1'b0, 1'b1, 8'h01};
        vecs[7]  = '{1'b1, 8'h05, 1'b1, 3, 1'b1, 1'b1, 8'h02};
        vecs[8]  = '{1'b1, 8'h05, 1'b0, 4, 1'b0, 1'b1, 8'h02};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 3, 1'b1, 1'b1, 8'h03};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 1'b1, 8'h04};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b1, 8'h05};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};

        // Reset state, with a clock edge while held in reset.
        @(posedge clock_port);
        #1;
        check("rst.level", 32'(level), 0);
        check("rst.out_valid", 32'(output_port_valid), 0);
        check("rst.in_ready", 32'(input_port_ready), 1);
        reset_port = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].vin, vecs[i].din, vecs[i].rdy);
            $display("vec %0d: vin=%0b din=%02h rdy=%0b -> level=%0d ov=%0b ir=%0b dout=%02h",
                     i, vecs[i].vin, vecs[i].din, vecs[i].rdy, level,
                     output_port_valid, input_port_ready, output_port_data);
            check($sformatf("vec%0d.level", i), 32'(level), 32'(vecs[i].exp_level));
            check($sformatf("vec%0d.in_ready", i), 32'(input_port_ready), 32'(vecs[i].exp_in_ready));
            check($sformatf("vec%0d.out_valid", i), 32'(output_port_valid), 32'(vecs[i].exp_out_valid));
            if (vecs[i].exp_out_valid)
                check($sformatf("vec%0d.data", i), 32'(output_port_data), 32'(vecs[i].exp_data));
        end

        // Streaming with continuous downstream acceptance across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, DW'(i), 1'b1);
            check($sformatf("stream%0d.data", i), 32'(output_port_data), 32'(i));
            check($sformatf("stream%0d.level", i), 32'(level), 1);
        end
        cycle(1'b0, 8'h00, 1'b1);
        check("stream.drained", 32'(level), 0);

        // Pacer that waits two cycles on a valid head before taking it.
        sent = 0; pcnt = 0; budget = 0; max_level = 0;
        rx.delete();
        while (rx.size() < 8 && budget < 200) begin
            prdy = output_port_valid && (pcnt == 2);
            if (prdy) begin
                rx.push_back(output_port_data);
                $display("pacer got %02h", output_port_data);
            end
            got = (sent < 8 && input_port_ready) ? 1 : 0;
            if (output_port_valid) pcnt = prdy ? 0 : pcnt + 1;
            cycle(sent < 8, DW'(8'h10 + sent), prdy);
            sent += got;
            if (32'(level) > max_level) max_level = 32'(level);
            budget++;
        end
        check("pacer.count", 32'(rx.size()), 8);
        for (int i = 0; i < rx.size(); i++)
            check($sformatf("pacer%0d.data", i), 32'(rx[i]), 32'(8'h10 + i));
        check("pacer.max_level_ok", 32'(max_level <= 4), 1);
        check("pacer.final_level", 32'(level), 0);
        input_port_valid  = 1'b0;
        output_port_ready = 1'b0;

        // Asynchronous reset mid-operation.
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        check("arst.pre_level", 32'(level), 3);
        input_port_valid = 1'b0;
        #2;
        reset_port = 1'b0;
        #1;
        mq.delete();
        check("arst.out_valid", 32'(output_port_valid), 0);
        check("arst.level", 32'(level), 0);
        check("arst.in_ready", 32'(input_port_ready), 1);
        @(posedge clock_port);
        #3;
        reset_port = 1'b1;
        cycle(1'b1, 8'h3C, 1'b0);
        check("arst.after_data", 32'(output_port_data), 32'h3C);
        check("arst.after_level", 32'(level), 1);
        cycle(1'b0, 8'h00, 1'b1);
        check_model("arst.drain");

        // Randomized traffic against the reference queue.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 99) < 60), DW'($urandom), 1'($urandom_range(0, 99) < 45));
            check_model($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
